// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU reservation station: issue into lowest free slot, CDB wakeup, lowest-index dispatch.
// Optional ALU_RS_WAKEUP_BYPASS_EN: an entry may dispatch in the same cycle its last operand is broadcast.
module alu_rs #(
    parameter int RS_SIZE       = 8,
    parameter int RS_TYPE_WIDTH = 6
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush,
    input  logic                     issue_en,
    input  logic [31:0]              issue_rob_id,
    input  logic [RS_TYPE_WIDTH-1:0] issue_type,
    input  logic [31:0]              issue_imm,
    input  logic                     issue_qj_busy,
    input  logic [31:0]              issue_qj,
    input  logic [31:0]              issue_vj,
    input  logic                     issue_qk_busy,
    input  logic [31:0]              issue_qk,
    input  logic [31:0]              issue_vk,
    input  logic                     cdb_rdy,
    input  logic [31:0]              cdb_rob_id,
    input  logic [31:0]              cdb_value,
    output logic                     full,
    output logic                     alu_en,
    output logic [31:0]              alu_rob_id,
    output logic [31:0]              alu_data_j,
    output logic [31:0]              alu_data_k,
    output logic [31:0]              alu_imm,
    output logic [RS_TYPE_WIDTH-1:0] alu_type
);
    localparam int IDX_W = $clog2(RS_SIZE);

    logic                     busy_q    [RS_SIZE];
    logic                     busy_d    [RS_SIZE];
    logic [31:0]              rob_id_q  [RS_SIZE];
    logic [31:0]              rob_id_d  [RS_SIZE];
    logic [RS_TYPE_WIDTH-1:0] typ_q     [RS_SIZE];
    logic [RS_TYPE_WIDTH-1:0] typ_d     [RS_SIZE];
    logic [31:0]              imm_q     [RS_SIZE];
    logic [31:0]              imm_d     [RS_SIZE];
    logic [31:0]              vj_q      [RS_SIZE];
    logic [31:0]              vj_d      [RS_SIZE];
    logic [31:0]              qj_q      [RS_SIZE];
    logic [31:0]              qj_d      [RS_SIZE];
    logic                     qj_busy_q [RS_SIZE];
    logic                     qj_busy_d [RS_SIZE];
    logic [31:0]              vk_q      [RS_SIZE];
    logic [31:0]              vk_d      [RS_SIZE];
    logic [31:0]              qk_q      [RS_SIZE];
    logic [31:0]              qk_d      [RS_SIZE];
    logic                     qk_busy_q [RS_SIZE];
    logic                     qk_busy_d [RS_SIZE];

    logic                     alu_en_q, alu_en_d;
    logic [31:0]              alu_rob_id_q, alu_rob_id_d;
    logic [31:0]              alu_data_j_q, alu_data_j_d;
    logic [31:0]              alu_data_k_q, alu_data_k_d;
    logic [31:0]              alu_imm_q, alu_imm_d;
    logic [RS_TYPE_WIDTH-1:0] alu_type_q, alu_type_d;

    logic [RS_SIZE-1:0]       ready;
    logic                     sel_valid;
    logic [IDX_W-1:0]         sel_idx;
    logic                     free_valid;
    logic [IDX_W-1:0]         free_idx;
    logic                     all_busy;
    logic [31:0]              sel_vj, sel_vk;
    logic                     issue_j_hit, issue_k_hit;

    assign issue_j_hit = issue_qj_busy && cdb_rdy && (issue_qj == cdb_rob_id);
    assign issue_k_hit = issue_qk_busy && cdb_rdy && (issue_qk == cdb_rob_id);

    // Selection and free-slot search look only at registered state, so a slot freed
    // this cycle cannot be reissued until the next one.
    always_comb begin : select_c
        ready      = '0;
        sel_valid  = 1'b0;
        sel_idx    = '0;
        free_valid = 1'b0;
        free_idx   = '0;
        all_busy   = 1'b1;
        for (int i = 0; i < RS_SIZE; i++) begin
`ifdef ALU_RS_WAKEUP_BYPASS_EN
            ready[i] = busy_q[i]
                && (!qj_busy_q[i] || (cdb_rdy && (qj_q[i] == cdb_rob_id)))
                && (!qk_busy_q[i] || (cdb_rdy && (qk_q[i] == cdb_rob_id)));
`else
            ready[i] = busy_q[i] && !qj_busy_q[i] && !qk_busy_q[i];
`endif
            if (!sel_valid && ready[i]) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!free_valid && !busy_q[i]) begin
                free_valid = 1'b1;
                free_idx   = IDX_W'(i);
            end
            all_busy = all_busy & busy_q[i];
        end
    end

    always_comb begin : operand_c
        sel_vj = vj_q[sel_idx];
        sel_vk = vk_q[sel_idx];
`ifdef ALU_RS_WAKEUP_BYPASS_EN
        // A still-pending operand on a selected entry can only be the one on the bus now.
        if (qj_busy_q[sel_idx]) sel_vj = cdb_value;
        if (qk_busy_q[sel_idx]) sel_vk = cdb_value;
`endif
    end

    always_comb begin : next_c
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_d[i]    = busy_q[i];
            rob_id_d[i]  = rob_id_q[i];
            typ_d[i]     = typ_q[i];
            imm_d[i]     = imm_q[i];
            vj_d[i]      = vj_q[i];
            qj_d[i]      = qj_q[i];
            qj_busy_d[i] = qj_busy_q[i];
            vk_d[i]      = vk_q[i];
            qk_d[i]      = qk_q[i];
            qk_busy_d[i] = qk_busy_q[i];
        end
        alu_en_d     = alu_en_q;
        alu_rob_id_d = alu_rob_id_q;
        alu_data_j_d = alu_data_j_q;
        alu_data_k_d = alu_data_k_q;
        alu_imm_d    = alu_imm_q;
        alu_type_d   = alu_type_q;

        if (rdy_in) begin
            alu_en_d = 1'b0;
            if (flush) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    busy_d[i] = 1'b0;
                end
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i] && cdb_rdy && qj_busy_q[i] && (qj_q[i] == cdb_rob_id)) begin
                        vj_d[i]      = cdb_value;
                        qj_busy_d[i] = 1'b0;
                    end
                    if (busy_q[i] && cdb_rdy && qk_busy_q[i] && (qk_q[i] == cdb_rob_id)) begin
                        vk_d[i]      = cdb_value;
                        qk_busy_d[i] = 1'b0;
                    end
                    if (sel_valid && (sel_idx == IDX_W'(i))) begin
                        busy_d[i] = 1'b0;
                    end
                    if (issue_en && free_valid && (free_idx == IDX_W'(i))) begin
                        busy_d[i]    = 1'b1;
                        rob_id_d[i]  = issue_rob_id;
                        typ_d[i]     = issue_type;
                        imm_d[i]     = issue_imm;
                        qj_d[i]      = issue_qj;
                        qk_d[i]      = issue_qk;
                        vj_d[i]      = issue_j_hit ? cdb_value : issue_vj;
                        vk_d[i]      = issue_k_hit ? cdb_value : issue_vk;
                        qj_busy_d[i] = issue_qj_busy && !issue_j_hit;
                        qk_busy_d[i] = issue_qk_busy && !issue_k_hit;
                    end
                end
                if (sel_valid) begin
                    alu_en_d     = 1'b1;
                    alu_rob_id_d = rob_id_q[sel_idx];
                    alu_data_j_d = sel_vj;
                    alu_data_k_d = sel_vk;
                    alu_imm_d    = imm_q[sel_idx];
                    alu_type_d   = typ_q[sel_idx];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                busy_q[i]    <= 1'b0;
                rob_id_q[i]  <= '0;
                typ_q[i]     <= '0;
                imm_q[i]     <= '0;
                vj_q[i]      <= '0;
                qj_q[i]      <= '0;
                qj_busy_q[i] <= 1'b0;
                vk_q[i]      <= '0;
                qk_q[i]      <= '0;
                qk_busy_q[i] <= 1'b0;
            end
            alu_en_q     <= 1'b0;
            alu_rob_id_q <= '0;
            alu_data_j_q <= '0;
            alu_data_k_q <= '0;
            alu_imm_q    <= '0;
            alu_type_q   <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                busy_q[i]    <= busy_d[i];
                rob_id_q[i]  <= rob_id_d[i];
                typ_q[i]     <= typ_d[i];
                imm_q[i]     <= imm_d[i];
                vj_q[i]      <= vj_d[i];
                qj_q[i]      <= qj_d[i];
                qj_busy_q[i] <= qj_busy_d[i];
                vk_q[i]      <= vk_d[i];
                qk_q[i]      <= qk_d[i];
                qk_busy_q[i] <= qk_busy_d[i];
            end
            alu_en_q     <= alu_en_d;
            alu_rob_id_q <= alu_rob_id_d;
            alu_data_j_q <= alu_data_j_d;
            alu_data_k_q <= alu_data_k_d;
            alu_imm_q    <= alu_imm_d;
            alu_type_q   <= alu_type_d;
        end
    end

    assign full       = all_busy;
    assign alu_en     = alu_en_q;
    assign alu_rob_id = alu_rob_id_q;
    assign alu_data_j = alu_data_j_q;
    assign alu_data_k = alu_data_k_q;
    assign alu_imm    = alu_imm_q;
    assign alu_type   = alu_type_q;

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - self-checking bench for alu_rs: directed scenarios plus randomized run against a reference model.
module tb_alu_rs;
    localparam int RS = 8;
    localparam int TW = 6;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int LAT = BYP ? 1 : 2;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, flush, issue_en;
    logic [31:0]   issue_rob_id, issue_imm, issue_qj, issue_vj, issue_qk, issue_vk;
    logic [TW-1:0] issue_type;
    logic          issue_qj_busy, issue_qk_busy;
    logic          cdb_rdy;
    logic [31:0]   cdb_rob_id, cdb_value;
    logic          full, alu_en;
    logic [31:0]   alu_rob_id, alu_data_j, alu_data_k, alu_imm;
    logic [TW-1:0] alu_type;

    int checks   = 0;
    int failures = 0;

    alu_rs #(.RS_SIZE(RS), .RS_TYPE_WIDTH(TW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .issue_en(issue_en), .issue_rob_id(issue_rob_id), .issue_type(issue_type),
        .issue_imm(issue_imm), .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj),
        .issue_vj(issue_vj), .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk),
        .issue_vk(issue_vk), .cdb_rdy(cdb_rdy), .cdb_rob_id(cdb_rob_id),
        .cdb_value(cdb_value), .full(full), .alu_en(alu_en), .alu_rob_id(alu_rob_id),
        .alu_data_j(alu_data_j), .alu_data_k(alu_data_k), .alu_imm(alu_imm),
        .alu_type(alu_type)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: a table of waiting instructions plus the last dispatched payload.
    typedef struct {
        logic          busy;
        logic [31:0]   rob, imm, vj, qj, vk, qk;
        logic          qjb, qkb;
        logic [TW-1:0] typ;
    } ent_t;

    ent_t          m [RS];
    logic          e_en;
    logic [31:0]   e_rob, e_j, e_k, e_imm;
    logic [TW-1:0] e_typ;

    function automatic bit operand_ok(input logic pending, input logic [31:0] tag);
        return !pending || (BYP && cdb_rdy && tag == cdb_rob_id);
    endfunction

    function automatic bit model_full();
        bit f = 1'b1;
        for (int i = 0; i < RS; i++) f = f && m[i].busy;
        return f;
    endfunction

    task automatic model_step();
        ent_t nx [RS];
        int   pick = -1;
        int   slot = -1;
        if (rst_in) begin
            for (int i = 0; i < RS; i++) m[i] = '{default: '0};
            e_en = 0; e_rob = 0; e_j = 0; e_k = 0; e_imm = 0; e_typ = 0;
            return;
        end
        if (!rdy_in) return;
        e_en = 1'b0;
        if (flush) begin
            for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
            return;
        end
        nx = m;
        for (int i = 0; i < RS; i++) begin
            if (pick < 0 && m[i].busy && operand_ok(m[i].qjb, m[i].qj) && operand_ok(m[i].qkb, m[i].qk)) pick = i;
            if (slot < 0 && !m[i].busy) slot = i;
            if (m[i].busy && cdb_rdy && m[i].qjb && m[i].qj == cdb_rob_id) begin nx[i].vj = cdb_value; nx[i].qjb = 0; end
            if (m[i].busy && cdb_rdy && m[i].qkb && m[i].qk == cdb_rob_id) begin nx[i].vk = cdb_value; nx[i].qkb = 0; end
        end
        if (pick >= 0) begin
            e_en  = 1'b1;
            e_rob = m[pick].rob;
            e_j   = m[pick].qjb ? cdb_value : m[pick].vj;
            e_k   = m[pick].qkb ? cdb_value : m[pick].vk;
            e_imm = m[pick].imm;
            e_typ = m[pick].typ;
            nx[pick].busy = 1'b0;
        end
        if (issue_en && slot >= 0) begin
            nx[slot].busy = 1'b1;
            nx[slot].rob  = issue_rob_id;
            nx[slot].imm  = issue_imm;
            nx[slot].typ  = issue_type;
            nx[slot].qj   = issue_qj;
            nx[slot].qk   = issue_qk;
            nx[slot].qjb  = issue_qj_busy && !(cdb_rdy && issue_qj == cdb_rob_id);
            nx[slot].qkb  = issue_qk_busy && !(cdb_rdy && issue_qk == cdb_rob_id);
            nx[slot].vj   = (issue_qj_busy && !nx[slot].qjb) ? cdb_value : issue_vj;
            nx[slot].vk   = (issue_qk_busy && !nx[slot].qkb) ? cdb_value : issue_vk;
        end
        m = nx;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        rst_in = 0; rdy_in = 1; flush = 0; issue_en = 0; cdb_rdy = 0;
        issue_rob_id = 0; issue_type = 0; issue_imm = 0;
        issue_qj_busy = 0; issue_qj = 0; issue_vj = 0;
        issue_qk_busy = 0; issue_qk = 0; issue_vk = 0;
        cdb_rob_id = 0; cdb_value = 0;
    endtask

    task automatic set_issue(input logic [31:0] rob, input logic [TW-1:0] typ, input logic [31:0] imm,
                             input logic qjb, input logic [31:0] qj, input logic [31:0] vj,
                             input logic qkb, input logic [31:0] qk, input logic [31:0] vk);
        issue_en = 1; issue_rob_id = rob; issue_type = typ; issue_imm = imm;
        issue_qj_busy = qjb; issue_qj = qj; issue_vj = vj;
        issue_qk_busy = qkb; issue_qk = qk; issue_vk = vk;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_in = 1;
        cycle();
        set_issue(1, 1, 0, 0, 0, 1, 0, 0, 2);
        flush = 1;
        cycle();
        idle_inputs();
        checks++; if (alu_en !== 1'b0) begin failures++; $display("FAIL reset_alu_en got=%0b exp=0", alu_en); end
        checks++; if ({alu_rob_id, alu_data_j, alu_data_k, alu_imm, alu_type} !== '0) begin
            failures++; $display("FAIL reset_payload got=%h exp=0", {alu_rob_id, alu_data_j, alu_data_k, alu_imm, alu_type}); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
        cycle();
        cycle();
        checks++; if (alu_en !== 1'b0) begin failures++; $display("FAIL reset_blocks_issue got=%0b exp=0", alu_en); end
    endtask

    task automatic test_basic();
        set_issue(5, 0, 0, 0, 0, 3, 0, 0, 4);
        cycle();
        idle_inputs();
        checks++; if (alu_en !== 1'b0) begin failures++; $display("FAIL basic_early got=%0b exp=0", alu_en); end
        cycle();
        checks++; if ({alu_en, alu_rob_id, alu_data_j, alu_data_k} !== {1'b1, 32'd5, 32'd3, 32'd4}) begin
            failures++; $display("FAIL basic_dispatch got=%h exp=%h", {alu_en, alu_rob_id, alu_data_j, alu_data_k}, {1'b1, 32'd5, 32'd3, 32'd4}); end
        cycle();
        checks++; if ({alu_en, alu_rob_id} !== {1'b0, 32'd5}) begin
            failures++; $display("FAIL basic_one_cycle got=%h exp=%h", {alu_en, alu_rob_id}, {1'b0, 32'd5}); end
    endtask

    task automatic test_wakeup();
        set_issue(7, 3, 32'h11, 1, 2, 0, 0, 0, 32'h20);
        cycle();
        idle_inputs();
        cycle();
        cycle();
        cdb_rdy = 1; cdb_rob_id = 2; cdb_value = 32'h10;
        for (int c = 1; c <= 3; c++) begin
            cycle();
            idle_inputs();
            checks++; if (alu_en !== (c == LAT)) begin
                failures++; $display("FAIL wakeup_en_c%0d got=%0b exp=%0b", c, alu_en, c == LAT); end
            if (c == LAT) begin
                checks++; if ({alu_rob_id, alu_data_j, alu_data_k} !== {32'd7, 32'h10, 32'h20}) begin
                    failures++; $display("FAIL wakeup_payload got=%h exp=%h", {alu_rob_id, alu_data_j, alu_data_k}, {32'd7, 32'h10, 32'h20}); end
            end
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < RS; i++) begin
            set_issue(100 + i, 1, 0, 1, 3, 0, 0, 0, i);
            cycle();
        end
        idle_inputs();
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_set got=%0b exp=1", full); end
        set_issue(200, 1, 0, 0, 0, 1, 0, 0, 1);
        cycle();
        idle_inputs();
        cycle();
        checks++; if ({full, alu_en} !== 2'b10) begin failures++; $display("FAIL full_ignore got=%b exp=10", {full, alu_en}); end
        cdb_rdy = 1; cdb_rob_id = 3; cdb_value = 32'h55;
        cycle();
        idle_inputs();
        for (int obs = 0; obs < RS + 3; obs++) begin
            automatic bit exp_en = (obs >= LAT - 1) && (obs < LAT - 1 + RS);
            checks++; if ({alu_en, full} !== {exp_en, obs < LAT - 1}) begin
                failures++; $display("FAIL drain_flags_o%0d got=%b exp=%b", obs, {alu_en, full}, {exp_en, obs < LAT - 1}); end
            if (exp_en) begin
                checks++; if ({alu_rob_id, alu_data_j, alu_data_k} !== {32'(100 + obs - LAT + 1), 32'h55, 32'(obs - LAT + 1)}) begin
                    failures++; $display("FAIL drain_order_o%0d got=%h exp=%h", obs, {alu_rob_id, alu_data_j, alu_data_k},
                                         {32'(100 + obs - LAT + 1), 32'h55, 32'(obs - LAT + 1)}); end
            end
            cycle();
        end
    endtask

    task automatic test_issue_bypass();
        set_issue(11, 2, 32'h77, 0, 0, 1, 1, 9, 0);
        cdb_rdy = 1; cdb_rob_id = 9; cdb_value = 32'hABCD;
        cycle();
        idle_inputs();
        cycle();
        checks++; if ({alu_en, alu_rob_id, alu_data_j, alu_data_k, alu_imm, alu_type} !==
                      {1'b1, 32'd11, 32'd1, 32'hABCD, 32'h77, 6'd2}) begin
            failures++; $display("FAIL issue_bypass got=%h exp=%h", {alu_en, alu_rob_id, alu_data_j, alu_data_k, alu_imm, alu_type},
                                 {1'b1, 32'd11, 32'd1, 32'hABCD, 32'h77, 6'd2}); end
        cycle();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_issue(30 + i, 0, 0, 1, 50, 0, 0, 0, 0);
            cycle();
        end
        idle_inputs();
        rdy_in = 0; flush = 1;
        cycle();
        idle_inputs();
        cdb_rdy = 1; cdb_rob_id = 50; cdb_value = 32'h99;
        cycle();
        idle_inputs();
        for (int obs = 0; obs < 5; obs++) begin
            automatic bit exp_en = (obs >= LAT - 1) && (obs < LAT + 2);
            checks++; if (alu_en !== exp_en) begin failures++; $display("FAIL noflush_en_o%0d got=%0b exp=%0b", obs, alu_en, exp_en); end
            if (exp_en) begin
                checks++; if ({alu_rob_id, alu_data_j} !== {32'(30 + obs - LAT + 1), 32'h99}) begin
                    failures++; $display("FAIL noflush_rob_o%0d got=%h exp=%h", obs, {alu_rob_id, alu_data_j}, {32'(30 + obs - LAT + 1), 32'h99}); end
            end
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            set_issue(40 + i, 0, 0, 1, 60, 0, 0, 0, 0);
            cycle();
        end
        set_issue(44, 0, 0, 0, 0, 5, 0, 0, 6);
        cycle();
        set_issue(43, 0, 0, 0, 0, 7, 0, 0, 8);
        flush = 1;
        cycle();
        idle_inputs();
        checks++; if ({alu_en, full} !== 2'b00) begin failures++; $display("FAIL flush_clear got=%b exp=00", {alu_en, full}); end
        cdb_rdy = 1; cdb_rob_id = 60; cdb_value = 32'h1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            idle_inputs();
            checks++; if (alu_en !== 1'b0) begin failures++; $display("FAIL flush_no_dispatch_c%0d got=%0b exp=0", c, alu_en); end
        end
    endtask

    task automatic test_random();
        idle_inputs();
        rst_in = 1;
        cycle();
        for (int n = 0; n < 3000; n++) begin
            rst_in        = ($urandom_range(0, 299) == 0);
            rdy_in        = ($urandom_range(0, 9) != 0);
            flush         = ($urandom_range(0, 39) == 0);
            issue_en      = $urandom_range(0, 1);
            issue_rob_id  = $urandom;
            issue_type    = TW'($urandom);
            issue_imm     = $urandom;
            issue_qj_busy = $urandom_range(0, 1);
            issue_qj      = $urandom_range(0, 7);
            issue_vj      = $urandom;
            issue_qk_busy = $urandom_range(0, 1);
            issue_qk      = $urandom_range(0, 7);
            issue_vk      = $urandom;
            cdb_rdy       = ($urandom_range(0, 2) == 0);
            cdb_rob_id    = $urandom_range(0, 7);
            cdb_value     = $urandom;
            cycle();
            checks++; if (alu_en !== e_en) begin failures++; $display("FAIL rand_en n=%0d got=%0b exp=%0b", n, alu_en, e_en); end
            checks++; if ({alu_rob_id, alu_data_j, alu_data_k, alu_imm, alu_type} !== {e_rob, e_j, e_k, e_imm, e_typ}) begin
                failures++; $display("FAIL rand_payload n=%0d got=%h exp=%h", n, {alu_rob_id, alu_data_j, alu_data_k, alu_imm, alu_type},
                                     {e_rob, e_j, e_k, e_imm, e_typ}); end
            checks++; if (full !== model_full()) begin failures++; $display("FAIL rand_full n=%0d got=%0b exp=%0b", n, full, model_full()); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_full();
        test_issue_bypass();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
